// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N-to-1 multiplexer.
package mux_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin finder: first enabled index after ptr, wrapping back to ptr itself.
module rr_next_sel
  import mux_scan_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [sel_width(N)-1:0] ptr,
  input  logic [N-1:0]            en,
  output logic [sel_width(N)-1:0] nxt,
  output logic                    any_en
);

  localparam int unsigned SELW = sel_width(N);

  logic [SELW-1:0] hi_idx;
  logic [SELW-1:0] lo_idx;
  logic            hi_found;

  // Smallest enabled index above ptr wins; otherwise smallest at or below ptr.
  always_comb begin
    hi_idx   = ptr;
    lo_idx   = ptr;
    hi_found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (en[i]) begin
        if (i > int'(ptr)) begin
          hi_idx   = SELW'(i);
          hi_found = 1'b1;
        end else begin
          lo_idx = SELW'(i);
        end
      end
    end
    nxt = hi_found ? hi_idx : lo_idx;
  end

  assign any_en = |en;

endmodule

// File: rtl/mux_n_scan.sv
// Registered N-to-1 mux with manual select and round-robin dwell scanning.
module mux_n_scan
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [sel_width(N)-1:0] sel,
  input  logic [N-1:0]            en,
  input  logic [N*WIDTH-1:0]      d,
  output logic [WIDTH-1:0]        y,
  output logic [sel_width(N)-1:0] ch,
  output logic                    valid,
  output logic                    wrap
);

  localparam int unsigned SELW = sel_width(N);
  localparam int unsigned CNTW = sel_width(DWELL);

  logic [SELW-1:0]  ptr;
  logic [CNTW-1:0]  cnt;

  logic [SELW-1:0]  nxt;
  logic             any_en;

  logic [WIDTH-1:0] sel_data;
  logic             sel_en;
  logic             sel_ok;
  logic [WIDTH-1:0] ptr_data;
  logic             ptr_en;
  logic             advance;

  logic [WIDTH-1:0] y_n;
  logic [SELW-1:0]  ch_n;
  logic             valid_n;
  logic             wrap_n;
  logic [SELW-1:0]  ptr_n;
  logic [CNTW-1:0]  cnt_n;

  rr_next_sel #(
    .N (N)
  ) u_next (
    .ptr    (ptr),
    .en     (en),
    .nxt    (nxt),
    .any_en (any_en)
  );

  // Decode-by-compare channel lookup so out-of-range selects never index past d/en.
  always_comb begin
    sel_data = '0;
    sel_en   = 1'b0;
    ptr_data = '0;
    ptr_en   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == SELW'(i)) begin
        sel_data = d[i*WIDTH +: WIDTH];
        sel_en   = en[i];
      end
      if (ptr == SELW'(i)) begin
        ptr_data = d[i*WIDTH +: WIDTH];
        ptr_en   = en[i];
      end
    end
    sel_ok = (32'(sel) < N);
  end

  // Next-state and next-output selection for both modes.
  always_comb begin
    y_n     = '0;
    ch_n    = ptr;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    ptr_n   = ptr;
    cnt_n   = '0;
    advance = 1'b0;

    if (mode_e'(mode) == MODE_MANUAL) begin
      valid_n = sel_ok && sel_en;
      y_n     = valid_n ? sel_data : '0;
      ch_n    = sel;
      ptr_n   = sel_ok ? sel : '0;
    end else begin
      ch_n    = ptr;
      valid_n = ptr_en;
      y_n     = ptr_en ? ptr_data : '0;
      // A disabled current channel is abandoned without finishing its dwell.
      advance = any_en && ((cnt == CNTW'(DWELL - 1)) || !ptr_en);
      if (advance) begin
        ptr_n  = nxt;
        cnt_n  = '0;
        wrap_n = (nxt <= ptr);
      end else begin
        cnt_n = any_en ? cnt + CNTW'(1) : '0;
      end
    end
  end

  // Output and scan state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      y     <= y_n;
      ch    <= ch_n;
      valid <= valid_n;
      wrap  <= wrap_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed checks of mux_n_scan: a 4x4 DWELL=2 instance and an 8x16 DWELL=1 instance.
module tb_mux_n_scan;

  logic        clk;
  int          total;
  int          bad;

  // 4-channel, 4-bit, dwell 2
  logic        rst4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [3:0]  en4;
  logic [15:0] d4;
  logic [3:0]  y4;
  logic [1:0]  ch4;
  logic        valid4;
  logic        wrap4;
  logic [7:0]  obs4;

  // 8-channel, 16-bit, dwell 1
  logic         rst8;
  logic         mode8;
  logic [2:0]   sel8;
  logic [7:0]   en8;
  logic [127:0] d8;
  logic [15:0]  y8;
  logic [2:0]   ch8;
  logic         valid8;
  logic         wrap8;
  logic [20:0]  obs8;

  assign obs4 = {y4, ch4, valid4, wrap4};
  assign obs8 = {y8, ch8, valid8, wrap8};

  mux_n_scan #(.N(4), .WIDTH(4), .DWELL(2)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .mode  (mode4),
    .sel   (sel4),
    .en    (en4),
    .d     (d4),
    .y     (y4),
    .ch    (ch4),
    .valid (valid4),
    .wrap  (wrap4)
  );

  mux_n_scan #(.N(8), .WIDTH(16), .DWELL(1)) dut8 (
    .clk   (clk),
    .reset (rst8),
    .mode  (mode8),
    .sel   (sel8),
    .en    (en8),
    .d     (d8),
    .y     (y8),
    .ch    (ch8),
    .valid (valid8),
    .wrap  (wrap8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst4  = 1'b1;
    rst8  = 1'b1;
    mode4 = 1'b0;
    sel4  = 2'd0;
    en4   = 4'b0000;
    d4    = {4'd8, 4'd4, 4'd2, 4'd1};
    mode8 = 1'b1;
    sel8  = 3'd0;
    en8   = 8'hFF;
    for (int i = 0; i < 8; i++) d8[i*16 +: 16] = 16'((i + 1) * 16'h0111);
    #1;
    total++;
    if (obs4 !== 8'h00) begin
      $display("FAIL reset4 got=%h want=%h", obs4, 8'h00);
      bad++;
    end
    total++;
    if (obs8 !== 21'h0) begin
      $display("FAIL reset8 got=%h want=%h", obs8, 21'h0);
      bad++;
    end
    @(negedge clk);
    rst4 = 1'b0;
    rst8 = 1'b0;
  endtask

  task automatic test_manual();
    logic [7:0] exp;
    // all enabled, sel=2 -> d2
    mode4 = 1'b0; en4 = 4'b1111; sel4 = 2'd2;
    @(posedge clk); #1;
    exp = {4'd4, 2'd2, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL manual_sel2 got=%h want=%h", obs4, exp); bad++; end
    sel4 = 2'd3;
    @(posedge clk); #1;
    exp = {4'd8, 2'd3, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL manual_sel3 got=%h want=%h", obs4, exp); bad++; end
    // channel 2 disabled
    en4 = 4'b1011; sel4 = 2'd2;
    @(posedge clk); #1;
    exp = {4'd0, 2'd2, 1'b0, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL manual_disabled got=%h want=%h", obs4, exp); bad++; end
    sel4 = 2'd0;
    @(posedge clk); #1;
    exp = {4'd1, 2'd0, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL manual_sel0 got=%h want=%h", obs4, exp); bad++; end
  endtask

  task automatic test_scan_all();
    int         exp_ch [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [7:0] exp;
    mode4 = 1'b0; sel4 = 2'd0; en4 = 4'b1111;
    @(posedge clk); #1;
    mode4 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      exp = {4'(1 << exp_ch[k]), 2'(exp_ch[k]), 1'b1, (k == 7)};
      total++;
      if (obs4 !== exp) begin $display("FAIL scan_all[%0d] got=%h want=%h", k, obs4, exp); bad++; end
    end
  endtask

  task automatic test_scan_sparse();
    int         exp_ch [6] = '{0, 0, 2, 2, 0, 0};
    logic [7:0] exp;
    mode4 = 1'b0; sel4 = 2'd0; en4 = 4'b0101;
    @(posedge clk); #1;
    mode4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      exp = {4'(1 << exp_ch[k]), 2'(exp_ch[k]), 1'b1, (k == 3)};
      total++;
      if (obs4 !== exp) begin $display("FAIL scan_sparse[%0d] got=%h want=%h", k, obs4, exp); bad++; end
    end
  endtask

  task automatic test_disable_mid();
    logic [7:0] exp;
    mode4 = 1'b0; sel4 = 2'd1; en4 = 4'b1111;
    @(posedge clk); #1;
    // start scanning at 1 with channel 1 dropped: shown once invalid, then skipped
    mode4 = 1'b1; en4 = 4'b1101;
    @(posedge clk); #1;
    exp = {4'd0, 2'd1, 1'b0, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL drop_ch1 got=%h want=%h", obs4, exp); bad++; end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      exp = {4'd4, 2'd2, 1'b1, 1'b0};
      total++;
      if (obs4 !== exp) begin $display("FAIL after_drop[%0d] got=%h want=%h", k, obs4, exp); bad++; end
    end
    // nothing enabled: ptr parked on 3, outputs idle
    en4 = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      exp = {4'd0, 2'd3, 1'b0, 1'b0};
      total++;
      if (obs4 !== exp) begin $display("FAIL en_zero[%0d] got=%h want=%h", k, obs4, exp); bad++; end
    end
    en4 = 4'b1111;
    @(posedge clk); #1;
    exp = {4'd8, 2'd3, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL restore0 got=%h want=%h", obs4, exp); bad++; end
    @(posedge clk); #1;
    exp = {4'd8, 2'd3, 1'b1, 1'b1};
    total++;
    if (obs4 !== exp) begin $display("FAIL restore1 got=%h want=%h", obs4, exp); bad++; end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    // scanning is at ch=0 next; switch to manual takes effect on the very next edge
    mode4 = 1'b0; sel4 = 2'd3; en4 = 4'b1111;
    @(posedge clk); #1;
    exp = {4'd8, 2'd3, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL scan_to_manual got=%h want=%h", obs4, exp); bad++; end
    // back to scan: starts at sel=3 with a fresh dwell
    mode4 = 1'b1;
    @(posedge clk); #1;
    exp = {4'd8, 2'd3, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL manual_to_scan0 got=%h want=%h", obs4, exp); bad++; end
    @(posedge clk); #1;
    exp = {4'd8, 2'd3, 1'b1, 1'b1};
    total++;
    if (obs4 !== exp) begin $display("FAIL manual_to_scan1 got=%h want=%h", obs4, exp); bad++; end
    // live data tracking within a dwell
    d4 = {4'd8, 4'd4, 4'd2, 4'd9};
    @(posedge clk); #1;
    exp = {4'd9, 2'd0, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL live_data got=%h want=%h", obs4, exp); bad++; end
    d4 = {4'd8, 4'd4, 4'd2, 4'd1};
  endtask

  task automatic test_async_reset();
    logic [20:0] exp8;
    logic [7:0]  exp;
    // both instances are mid-scan; reset lands between edges
    mode4 = 1'b1; en4 = 4'b1111;
    @(posedge clk); #1;
    #2;
    rst4 = 1'b1;
    rst8 = 1'b1;
    #1;
    total++;
    if (obs4 !== 8'h00) begin $display("FAIL async_rst4 got=%h want=%h", obs4, 8'h00); bad++; end
    total++;
    if (obs8 !== 21'h0) begin $display("FAIL async_rst8 got=%h want=%h", obs8, 21'h0); bad++; end
    @(posedge clk); #1;
    total++;
    if (obs8 !== 21'h0) begin $display("FAIL rst8_held got=%h want=%h", obs8, 21'h0); bad++; end
    @(negedge clk);
    rst4 = 1'b0;
    rst8 = 1'b0;
    @(posedge clk); #1;
    exp = {4'd1, 2'd0, 1'b1, 1'b0};
    total++;
    if (obs4 !== exp) begin $display("FAIL post_rst4 got=%h want=%h", obs4, exp); bad++; end
    exp8 = {16'h0111, 3'd0, 1'b1, 1'b0};
    total++;
    if (obs8 !== exp8) begin $display("FAIL scan8[0] got=%h want=%h", obs8, exp8); bad++; end
    for (int k = 1; k < 9; k++) begin
      @(posedge clk); #1;
      exp8 = {16'(((k % 8) + 1) * 16'h0111), 3'(k % 8), 1'b1, (k == 7)};
      total++;
      if (obs8 !== exp8) begin $display("FAIL scan8[%0d] got=%h want=%h", k, obs8, exp8); bad++; end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_manual();
    test_scan_all();
    test_scan_sparse();
    test_disable_mid();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
